// File: rtl/text_line_prefetcher.sv
`default_nettype none
// ============================================================================
// Module   : text_line_prefetcher
// Purpose  : Per-scanline font prefetch for the scaled message renderer.
//            During hblank one glyph row per message character is fetched
//            from the shared 8x8 font ROM into a line buffer; during the
//            active region the buffered bits are replicated SCALE times and
//            turned into a registered pixel colour (1 cycle latency).
// Ports    : clk, rst            - pixel clock, async active-high reset
//            line_start, line_y  - upcoming-line pulse and its y
//            x, active_pixels    - current pixel position / visible flag
//            char_idx, char_code - message store lookup (combinational)
//            font_req/gnt/code/row/bits - font ROM arbiter handshake
//            busy, overrun       - fetch in progress / sticky error flag
//            color_out           - registered 24-bit pixel colour
// Options  : TEXT_PREFETCH_SKIP_SPACE_EN - spaces (8'd32) are not fetched;
//            a zero row is written instead, costing one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module text_line_prefetcher #(
    parameter int          SCALE    = 2,
    parameter int          MSG_LEN  = 11,
    parameter logic [9:0]  ORIGIN_X = 10'd232,
    parameter logic [9:0]  ORIGIN_Y = 10'd50,
    parameter logic [23:0] FG       = 24'hFFFFFF,
    parameter logic [23:0] BG       = 24'h5E8F54
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        line_start,
    input  logic [9:0]  line_y,
    input  logic [9:0]  x,
    input  logic        active_pixels,
    output logic [3:0]  char_idx,
    input  logic [7:0]  char_code,
    output logic        font_req,
    input  logic        font_gnt,
    output logic [7:0]  font_code,
    output logic [2:0]  font_row,
    input  logic [7:0]  font_bits,
    output logic        busy,
    output logic        overrun,
    output logic [23:0] color_out
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] REQ   = 2'd2;
    localparam logic [1:0] WAIT  = 2'd3;

    localparam int          C_SH    = $clog2(SCALE);
    localparam int          C_CSH   = C_SH + 3;
    localparam logic [9:0]  C_ROWS  = 10'(8 * SCALE);
    localparam logic [10:0] C_BOX_W = 11'(MSG_LEN * 8 * SCALE);
    localparam logic [3:0]  C_LAST  = 4'(MSG_LEN - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [2:0]  row_q, row_d;
    logic        line_on_q, line_on_d;
    logic        row_valid_q, row_valid_d;
    logic        start_q;
    logic [9:0]  line_y_q;
    logic        overrun_q;
    logic [23:0] color_q, color_d;
    logic [7:0]  line_buf_q [MSG_LEN];

    logic        w_buf_we;
    logic [7:0]  w_buf_wdata;
    logic        w_is_space;
    logic [9:0]  w_yr;
    logic [2:0]  w_row;
    logic [9:0]  w_xr;
    logic        w_in_box;
    logic [3:0]  w_cidx;
    logic [2:0]  w_sub;
    logic        w_bit;
    logic        w_overrun_set;

`ifdef TEXT_PREFETCH_SKIP_SPACE_EN
    assign w_is_space = (char_code == 8'd32);
`else
    assign w_is_space = 1'b0;
`endif

    // Row offset inside the text box; a line above the box wraps to a large
    // value and therefore fails the range check as well.
    assign w_yr  = line_y_q - ORIGIN_Y;
    assign w_row = 3'(w_yr >> C_SH);

    // Pixel position inside the box; x left of the box wraps the same way.
    assign w_xr     = x - ORIGIN_X;
    assign w_in_box = ({1'b0, w_xr} < C_BOX_W);
    assign w_cidx   = 4'(w_xr >> C_CSH);
    assign w_sub    = 3'(w_xr >> C_SH);
    // Glyph bit 7 is the leftmost pixel, so the column index is inverted.
    assign w_bit    = line_buf_q[w_cidx][~w_sub];

    // line_start is registered first; the FSM reacts to the registered copy,
    // so the restart after a collision is seen as one CHECK cycle with
    // font_req low. A grant still in flight when start_q arrives is dropped
    // because WAIT is abandoned without writing the buffer.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        row_d       = row_q;
        line_on_d   = line_on_q;
        row_valid_d = row_valid_q;
        w_buf_we    = 1'b0;
        w_buf_wdata = font_bits;
        if (start_q) begin
            state_d     = CHECK;
            idx_d       = 4'd0;
            row_valid_d = 1'b0;
        end else begin
            case (state_q)
                CHECK: begin
                    if (w_yr < C_ROWS) begin
                        line_on_d = 1'b1;
                        row_d     = w_row;
                        idx_d     = 4'd0;
                        state_d   = REQ;
                    end else begin
                        line_on_d = 1'b0;
                        state_d   = IDLE;
                    end
                end
                REQ: begin
                    if (w_is_space) begin
                        w_buf_we    = 1'b1;
                        w_buf_wdata = 8'h00;
                        if (idx_q == C_LAST) begin
                            row_valid_d = 1'b1;
                            state_d     = IDLE;
                        end else begin
                            idx_d   = idx_q + 4'd1;
                            state_d = REQ;
                        end
                    end else if (font_gnt) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    w_buf_we = 1'b1;
                    if (idx_q == C_LAST) begin
                        row_valid_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = REQ;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Overrun: a new line announced while the previous fetch is still
    // pending, or visible box pixels requested before the row is ready.
    assign w_overrun_set = (line_start && ((state_q != IDLE) || start_q)) ||
                           (active_pixels && line_on_q && !row_valid_q && w_in_box);

    always_comb begin
        color_d = 24'd0;
        if (active_pixels) begin
            if (line_on_q && row_valid_q && w_in_box) begin
                color_d = w_bit ? FG : BG;
            end else begin
                color_d = BG;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= 4'd0;
            row_q       <= 3'd0;
            line_on_q   <= 1'b0;
            row_valid_q <= 1'b0;
            start_q     <= 1'b0;
            line_y_q    <= 10'd0;
            overrun_q   <= 1'b0;
            color_q     <= 24'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            row_q       <= row_d;
            line_on_q   <= line_on_d;
            row_valid_q <= row_valid_d;
            start_q     <= line_start;
            if (line_start) begin
                line_y_q <= line_y;
            end
            overrun_q   <= overrun_q | w_overrun_set;
            color_q     <= color_d;
        end
    end

    // Buffer contents are only meaningful while row_valid is set, so no reset.
    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            line_buf_q[idx_q] <= w_buf_wdata;
        end
    end

    // ROM-facing outputs are decoded from state so they fall together with
    // the asynchronous reset and stay stable for the whole REQ stall.
    assign font_req  = (state_q == REQ) && !w_is_space;
    assign font_code = (state_q == REQ) ? char_code : 8'd0;
    assign font_row  = (state_q == REQ) ? row_q : 3'd0;
    assign char_idx  = idx_q;
    assign busy      = (state_q != IDLE);
    assign overrun   = overrun_q;
    assign color_out = color_q;

endmodule
`default_nettype wire

// File: tb/tb_text_line_prefetcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_text_line_prefetcher
// Purpose  : Directed self-checking bench for text_line_prefetcher with a
//            one-cycle font ROM model (data = code ^ row).
// Revision : 1.0 - initial release
// ============================================================================
module tb_text_line_prefetcher;

    localparam logic [23:0] C_FG = 24'hFFFFFF;
    localparam logic [23:0] C_BG = 24'h5E8F54;

    logic        clk;
    logic        rst;
    logic        line_start;
    logic [9:0]  line_y;
    logic [9:0]  x;
    logic        active_pixels;
    logic [3:0]  char_idx;
    logic [7:0]  char_code;
    logic        font_req;
    logic        font_gnt;
    logic [7:0]  font_code;
    logic [2:0]  font_row;
    logic [7:0]  font_bits;
    logic        busy;
    logic        overrun;
    logic [23:0] color_out;

    logic [7:0] msg [16];
    int n_checks;
    int n_errors;
    int q_idx[$];
    int q_code[$];
    int q_row[$];

    text_line_prefetcher dut (
        .clk          (clk),
        .rst          (rst),
        .line_start   (line_start),
        .line_y       (line_y),
        .x            (x),
        .active_pixels(active_pixels),
        .char_idx     (char_idx),
        .char_code    (char_code),
        .font_req     (font_req),
        .font_gnt     (font_gnt),
        .font_code    (font_code),
        .font_row     (font_row),
        .font_bits    (font_bits),
        .busy         (busy),
        .overrun      (overrun),
        .color_out    (color_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign char_code = msg[char_idx];

    // Font ROM: data valid the cycle after the grant.
    always @(posedge clk) begin
        if (font_req && font_gnt) begin
            font_bits <= font_code ^ {5'b0, font_row};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_msg(input string s);
        for (int i = 0; i < 16; i++) begin
            msg[i] = (i < s.len()) ? s[i] : 8'd0;
        end
    endtask

    function automatic logic [23:0] exp_pix(input int xv, input logic [2:0] row);
        int xr;
        int c;
        int b;
        logic [7:0] bits;
        xr = (xv - 232) & 10'h3FF;
        if (xr >= 176) return C_BG;
        c = xr / 16;
        b = 7 - (xr % 16) / 2;
        bits = msg[c] ^ {5'b0, row};
`ifdef TEXT_PREFETCH_SKIP_SPACE_EN
        if (msg[c] == 8'd32) bits = 8'h00;
`endif
        return bits[b] ? C_FG : C_BG;
    endfunction

    // Returns at edge k + #1, where edge k is the one sampling line_start.
    task automatic start_line(input logic [9:0] y);
        @(posedge clk);
        #1;
        line_y     = y;
        line_start = 1'b1;
        @(posedge clk);
        #1;
        line_start = 1'b0;
    endtask

    // At the negedge with index off the DUT state reflects edge k+off.
    task automatic run_fetch(input logic [9:0] y, input int stall_idx, input int stall_len,
                             input int restart_edge, output int done_off, output int busy_cyc);
        int   stall_cnt;
        bit   stalled;
        logic [7:0] s_code;
        logic [2:0] s_row;
        q_idx.delete();
        q_code.delete();
        q_row.delete();
        font_gnt  = 1'b1;
        stall_cnt = 0;
        stalled   = 1'b0;
        s_code    = 8'd0;
        s_row     = 3'd0;
        done_off  = -1;
        busy_cyc  = 0;
        start_line(y);
        for (int off = 0; off < 200; off++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (restart_edge >= 0) begin
                if (off == restart_edge - 1) begin
                    line_y     = y;
                    line_start = 1'b1;
                end
                if (off == restart_edge) begin
                    line_start = 1'b0;
                    check("overrun_set", overrun, 1);
                end
                if (off == restart_edge + 1) begin
                    check("restart_gap_req", font_req, 0);
                    check("restart_gap_idx", char_idx, 0);
                end
                if (off == restart_edge + 2) begin
                    check("restart_req", font_req, 1);
                    check("restart_idx", char_idx, 0);
                end
            end
            if (stall_cnt > 0) begin
                check("stall_req", font_req, 1);
                check("stall_code", font_code, s_code);
                check("stall_row", font_row, s_row);
                stall_cnt--;
                if (stall_cnt == 0) font_gnt = 1'b1;
            end else if (!stalled && stall_len > 0 && font_req && char_idx == 4'(stall_idx)) begin
                stalled   = 1'b1;
                font_gnt  = 1'b0;
                stall_cnt = stall_len;
                s_code    = font_code;
                s_row     = font_row;
            end
            if (font_req && font_gnt) begin
                q_idx.push_back(int'(char_idx));
                q_code.push_back(int'(font_code));
                q_row.push_back(int'(font_row));
            end
            if (off >= 2 && !busy) begin
                done_off = off;
                break;
            end
        end
        if (done_off < 0) check("fetch_timeout_busy", busy, 0);
        if (stall_len > 0) check("stall_seen", stalled, 1);
    endtask

    task automatic sweep(input int x0, input int x1, input logic [2:0] row);
        for (int xv = x0; xv <= x1; xv++) begin
            x = 10'(xv);
            active_pixels = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("pix_x%0d", xv), color_out, exp_pix(xv, row));
        end
        active_pixels = 1'b0;
    endtask

    task automatic check_reqs(input int n, input logic [2:0] row);
        check("req_count", q_idx.size(), n);
        for (int i = 0; i < q_idx.size() && i < n; i++) begin
            check($sformatf("req_idx%0d", i), q_idx[i], i);
            check($sformatf("req_code%0d", i), q_code[i], msg[i]);
            check($sformatf("req_row%0d", i), q_row[i], row);
        end
    endtask

    initial begin
        int done;
        int bcyc;
        int nreq;
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        line_start    = 1'b0;
        line_y        = 10'd0;
        x             = 10'd0;
        active_pixels = 1'b0;
        font_gnt      = 1'b1;
        set_msg("MINESWEEPER");

        // ---------------- reset values ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_color", color_out, 0);
        check("rst_req", font_req, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_idx", char_idx, 0);
        check("rst_code", font_code, 0);
        check("rst_row", font_row, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // ---------------- reset mid-fetch ----------------
        start_line(10'd50);
        repeat (4) @(posedge clk);
        #1;
        check("mid_req_before", font_req, 1);
        check("mid_idx_before", char_idx, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_req", font_req, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_idx", char_idx, 0);
        check("mid_rst_code", font_code, 0);
        check("mid_rst_color", color_out, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        nreq = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (font_req) nreq++;
        end
        check("post_rst_no_req", nreq, 0);

        // ---------------- in-box line, row 0 ----------------
        run_fetch(10'd50, -1, 0, -1, done, bcyc);
        check("inbox_done", done, 24);
        check("inbox_busy_cycles", bcyc, 23);
        check_reqs(11, 3'd0);
        if (q_code.size() == 11) begin
            check("code_first_M", q_code[0], 77);
            check("code_last_R", q_code[10], 82);
        end
        sweep(224, 415, 3'd0);
        x = 10'd0;
        active_pixels = 1'b1;
        @(posedge clk);
        #1 check("wrap_x0_bg", color_out, C_BG);
        active_pixels = 1'b0;
        x = 10'd234;
        @(posedge clk);
        #1 check("inactive_zero", color_out, 0);
        active_pixels = 1'b1;
        @(posedge clk);
        #1 check("lat_fg", color_out, C_FG);
        x = 10'd232;
        #2 check("lat_hold", color_out, C_FG);
        @(posedge clk);
        #1 check("lat_bg", color_out, C_BG);
        active_pixels = 1'b0;
        check("no_overrun_1", overrun, 0);

        // ---------------- out-of-box lines ----------------
        run_fetch(10'd66, -1, 0, -1, done, bcyc);
        check("oob_done", done, 2);
        check("oob_busy_cycles", bcyc, 1);
        check("oob_no_req", q_idx.size(), 0);
        for (int xv = 232; xv < 420; xv += 23) begin
            x = 10'(xv);
            active_pixels = 1'b1;
            @(posedge clk);
            #1 check($sformatf("oob_pix_x%0d", xv), color_out, C_BG);
        end
        active_pixels = 1'b0;
        @(posedge clk);
        #1 check("oob_inactive_zero", color_out, 0);
        run_fetch(10'd10, -1, 0, -1, done, bcyc);
        check("above_box_done", done, 2);
        check("above_box_no_req", q_idx.size(), 0);
        check("no_overrun_2", overrun, 0);

        // ---------------- grant stall, row 1 ----------------
        run_fetch(10'd53, 3, 5, -1, done, bcyc);
        check("stall_done", done, 29);
        check_reqs(11, 3'd1);
        sweep(232, 300, 3'd1);
        check("no_overrun_3", overrun, 0);

        // ---------------- overrun ----------------
        run_fetch(10'd50, -1, 0, 10, done, bcyc);
        check("restart_done", done, 34);
        check("overrun_sticky_1", overrun, 1);
        start_line(10'd50);
        repeat (3) @(posedge clk);
        #1;
        x = 10'd234;
        active_pixels = 1'b1;
        @(posedge clk);
        #1 check("pix_during_fetch_bg", color_out, C_BG);
        active_pixels = 1'b0;
        for (int i = 0; i < 100 && busy; i++) begin
            @(posedge clk);
            #1;
        end
        check("fetch_complete", busy, 0);
        active_pixels = 1'b1;
        @(posedge clk);
        #1 check("pix_after_fetch_fg", color_out, C_FG);
        active_pixels = 1'b0;
        check("overrun_sticky_2", overrun, 1);

`ifdef TEXT_PREFETCH_SKIP_SPACE_EN
        // ---------------- skipped space ----------------
        set_msg("MINE WEEPER");
        run_fetch(10'd50, -1, 0, -1, done, bcyc);
        check("space_done", done, 23);
        check("space_req_count", q_idx.size(), 10);
        nreq = 0;
        foreach (q_idx[i]) if (q_idx[i] == 4) nreq++;
        check("space_no_req_idx4", nreq, 0);
        sweep(296, 311, 3'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
